multi_pane_console: RTL
=======================

// Module: multi_pane_console
// PURPOSE
//  Next-generation console top: composites NUM_GAMES independent game engines into equal vertical panes of one VGA frame.
//  Supplies each pane with local coordinates and pause control.
//  Owns the shared game-status FSM (start/pause/win/lose/regenerate), the rating counter and the banner overlay.
//  Sits between the VGA timing block / button debouncers and the per-game engine+graphic pairs.
// PARAMETERS
//  NUM_GAMES      2     number of panes/game channels (1..8); SCREEN_WIDTH % NUM_GAMES == 0
//  SCREEN_WIDTH   800   active pixels per line
//  SCREEN_HEIGHT  600   active lines
//  RATING_WIDTH   8     rating counter width (<=16)
//  BANNER_HOLD    50000000  cycles the WIN banner is held before auto-regenerate
//  BKG_COLOR      12'h000   RGB444 shown in disabled panes
// PORTS
//  clk              in   1            system clock
//  arst_n           in   1            asynchronous active-low reset
//  i_h_coord        in   11           VGA horizontal coordinate
//  i_v_coord        in   10           VGA vertical coordinate
//  i_disp_enbl      in   1            display enable; 0 forces black
//  i_pane_en        in   NUM_GAMES    per-pane enable (e.g. from switches)
//  i_game_rgb       in   12*NUM_GAMES RGB444 from each pane graphic, pane k at [12k+:12]
//  i_banner_rgb     in   12           banner pixel for o_banner_num
//  i_game_win       in   NUM_GAMES    per-game win pulse/level
//  i_game_lose      in   NUM_GAMES    per-game lose pulse/level
//  i_ready          in   1            all engines finished level regeneration
//  i_start          in   1            start/resume button (debounced level)
//  i_pause          in   1            pause button (debounced level)
//  i_timer          in   16           timer value for quad display
//  o_local_x        out  11           pixel x relative to current pane origin
//  o_local_y        out  10           pixel y (= i_v_coord)
//  o_pane_idx       out  3            pane containing i_h_coord
//  o_red/o_green/o_blue out 4 each    composited pixel, registered
//  o_pause          out  1            1 whenever FSM not in RUN; broadcast to all engines
//  o_regenerate_level out 1           high in REGEN
//  o_banner_num     out  2            banner image index
//  o_rating         out  RATING_WIDTH current rating
//  o_quad_disp      out  32           {i_timer, zero-extended o_rating}
// BEHAVIOUR
//  - Reset: FSM=START, rating=0, o_rgb=0, o_pause=1, o_regenerate_level=0, o_banner_num=0, button-history regs=1.
//  - Button edges: rising edge = level & ~prev. prev resets to 1, so a button held through reset gives no edge.
//  - Pane map: PW=SCREEN_WIDTH/NUM_GAMES; o_pane_idx=i_h_coord/PW; o_local_x=i_h_coord-idx*PW.
//    All combinational, same cycle. h>=SCREEN_WIDTH -> idx=NUM_GAMES-1, local_x saturates to PW-1.
//  - Pixel out: registered, latency 1 cycle from coordinates.
//    Priority: ~i_disp_enbl -> 0; FSM!=RUN -> i_banner_rgb; ~i_pane_en[idx] -> BKG_COLOR; else i_game_rgb[idx].
//  - Active set: win/lose bits are ANDed with i_pane_en. Disabled games never end the round.
//  - FSM states / banner: START(0) REGEN(-) RUN(-) PAUSE(1) WIN(2) LOSE(3). During REGEN the banner holds its previous value.
//    START : start edge -> REGEN
//    REGEN : o_regenerate_level=1; i_ready -> RUN (same-cycle i_ready on entry still takes one REGEN cycle)
//    RUN   : any active lose -> LOSE; else any active win -> WIN; else pause edge -> PAUSE. Lose beats win beats pause.
//    PAUSE : start edge -> RUN (no regeneration); pause edge ignored
//    WIN   : on entry rating+=1, saturating at 2^RATING_WIDTH-1; hold counter counts BANNER_HOLD cycles -> REGEN; start edge skips the wait -> REGEN
//    LOSE  : on entry rating=0; start edge -> REGEN
//  - i_pane_en==0 in RUN: no pane can win or lose; the game stays in RUN until paused.
//  - Reset mid-frame or mid-state: immediate return to reset values; the hold counter clears.
// TESTING
//  1 reset, i_start held high across arst_n release -> FSM stays START; banner 0; o_pause=1
//  2 NUM_GAMES=2, h=399 -> idx0 local_x 399; h=400 -> idx1 local_x 0; RGB follows one cycle later; h=850 -> idx1 local_x 399
//  3 start edge, i_ready after 5 cycles -> regen high exactly 6 cycles, then RUN, o_pause=0, game pixels shown
//  4 RUN, lose[1] and win[0] same cycle -> LOSE, rating 0, banner 3; with pane_en=2'b01 same stimulus -> WIN, rating+1
//  5 rating=255, win -> stays 255; BANNER_HOLD=10 -> REGEN after 10 cycles
//  6 RUN, pause edge -> PAUSE, banner 1; start edge -> RUN without regen; i_disp_enbl=0 -> RGB 0 next cycle

Source files
------------

// File: rtl/multi_pane_console.sv
// Multi-pane console top: splits the frame into equal vertical panes, composites
// per-game pixels and runs the shared game-status FSM, rating and banner.
module multi_pane_console #(
    parameter int          NUM_GAMES     = 2,
    parameter int          SCREEN_WIDTH  = 800,
    parameter int          SCREEN_HEIGHT = 600,
    parameter int          RATING_WIDTH  = 8,
    parameter int          BANNER_HOLD   = 50000000,
    parameter logic [11:0] BKG_COLOR     = 12'h000
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [10:0]               i_h_coord,
    input  logic [9:0]                i_v_coord,
    input  logic                      i_disp_enbl,
    input  logic [NUM_GAMES-1:0]      i_pane_en,
    input  logic [12*NUM_GAMES-1:0]   i_game_rgb,
    input  logic [11:0]               i_banner_rgb,
    input  logic [NUM_GAMES-1:0]      i_game_win,
    input  logic [NUM_GAMES-1:0]      i_game_lose,
    input  logic                      i_ready,
    input  logic                      i_start,
    input  logic                      i_pause,
    input  logic [15:0]               i_timer,
    output logic [10:0]               o_local_x,
    output logic [9:0]                o_local_y,
    output logic [2:0]                o_pane_idx,
    output logic [3:0]                o_red,
    output logic [3:0]                o_green,
    output logic [3:0]                o_blue,
    output logic                      o_pause,
    output logic                      o_regenerate_level,
    output logic [1:0]                o_banner_num,
    output logic [RATING_WIDTH-1:0]   o_rating,
    output logic [31:0]               o_quad_disp
);

    localparam int PW = SCREEN_WIDTH / NUM_GAMES;
    localparam int HW = $clog2(BANNER_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(BANNER_HOLD - 1);

    typedef enum logic [2:0] {
        S_START,
        S_REGEN,
        S_RUN,
        S_PAUSE,
        S_WIN,
        S_LOSE
    } state_t;

    state_t                  state_q, state_d;
    logic [RATING_WIDTH-1:0] rating_q, rating_d;
    logic [HW-1:0]           hold_q, hold_d;
    logic [1:0]              banner_q, banner_d;
    logic [11:0]             rgb_q, rgb_d;
    logic                    start_prev_q, pause_prev_q;

    logic                    start_edge, pause_edge;
    logic                    any_win, any_lose;
    logic [2:0]              pane_idx;
    logic [10:0]             local_x;
    logic                    pane_on;
    logic [11:0]             pane_rgb;

    // prev regs reset to 1 so a button held through reset is not an edge
    assign start_edge = i_start & ~start_prev_q;
    assign pause_edge = i_pause & ~pause_prev_q;
    assign any_win    = |(i_game_win & i_pane_en);
    assign any_lose   = |(i_game_lose & i_pane_en);

    always_comb begin
        pane_idx = '0;
        local_x  = i_h_coord;
        pane_on  = i_pane_en[0];
        pane_rgb = i_game_rgb[11:0];
        for (int k = 1; k < NUM_GAMES; k++) begin
            if (i_h_coord >= 11'(k * PW)) begin
                pane_idx = 3'(k);
                local_x  = i_h_coord - 11'(k * PW);
                pane_on  = i_pane_en[k];
                pane_rgb = i_game_rgb[12*k +: 12];
            end
        end
        if (i_h_coord >= 11'(SCREEN_WIDTH)) begin
            local_x = 11'(PW - 1);
        end
    end

    always_comb begin
        rgb_d = pane_rgb;
        if (!i_disp_enbl) begin
            rgb_d = 12'h000;
        end else if (state_q != S_RUN) begin
            rgb_d = i_banner_rgb;
        end else if (!pane_on) begin
            rgb_d = BKG_COLOR;
        end
    end

    always_comb begin
        state_d  = state_q;
        rating_d = rating_q;
        hold_d   = hold_q;
        banner_d = banner_q;
        unique case (state_q)
            S_START: if (start_edge) state_d = S_REGEN;
            S_REGEN: if (i_ready) state_d = S_RUN;
            S_RUN: begin
                if (any_lose)        state_d = S_LOSE;
                else if (any_win)    state_d = S_WIN;
                else if (pause_edge) state_d = S_PAUSE;
            end
            S_PAUSE: if (start_edge) state_d = S_RUN;
            S_WIN: begin
                if (start_edge || hold_q == HOLD_LAST) state_d = S_REGEN;
                else hold_d = hold_q + 1'b1;
            end
            S_LOSE: if (start_edge) state_d = S_REGEN;
            default: state_d = S_START;
        endcase
        // entry actions; REGEN and RUN keep the previous banner
        if (state_d != state_q) begin
            unique case (state_d)
                S_PAUSE: banner_d = 2'd1;
                S_WIN: begin
                    banner_d = 2'd2;
                    hold_d   = '0;
                    if (rating_q != '1) rating_d = rating_q + 1'b1;
                end
                S_LOSE: begin
                    banner_d = 2'd3;
                    rating_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= S_START;
            rating_q     <= '0;
            hold_q       <= '0;
            banner_q     <= 2'd0;
            rgb_q        <= 12'h000;
            start_prev_q <= 1'b1;
            pause_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            rating_q     <= rating_d;
            hold_q       <= hold_d;
            banner_q     <= banner_d;
            rgb_q        <= rgb_d;
            start_prev_q <= i_start;
            pause_prev_q <= i_pause;
        end
    end

    assign o_local_x          = local_x;
    assign o_local_y          = i_v_coord;
    assign o_pane_idx         = pane_idx;
    assign o_red              = rgb_q[11:8];
    assign o_green            = rgb_q[7:4];
    assign o_blue             = rgb_q[3:0];
    assign o_pause            = (state_q != S_RUN);
    assign o_regenerate_level = (state_q == S_REGEN);
    assign o_banner_num       = banner_q;
    assign o_rating           = rating_q;
    assign o_quad_disp        = {i_timer, 16'(rating_q)};

endmodule
